// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : Shared encodings and types for the AHB request arbiter.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] INSTR_IDLE  = 2'b00;
    localparam logic [1:0] INSTR_READ  = 2'b01;
    localparam logic [1:0] INSTR_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_READ  = 1'b0,
        OWN_WRITE = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/ahb_req_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-input round-robin grant; contested requests go to the side
//            that did not win the previous grant.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import ahb_pkg::*;
(
    input  logic   HCLK,
    input  logic   HRESET,
    input  logic   i_req_rd,
    input  logic   i_req_wr,
    input  logic   i_update,
    output logic   o_valid,
    output owner_t o_owner
);

    owner_t r_last_grant;

    always_comb begin
        o_valid = i_req_rd | i_req_wr;
        o_owner = OWN_WRITE;
        if (i_req_rd && i_req_wr) begin
            if (r_last_grant == OWN_WRITE) begin
                o_owner = OWN_READ;
            end else begin
                o_owner = OWN_WRITE;
            end
        end else if (i_req_rd) begin
            o_owner = OWN_READ;
        end
    end

    // Reset to WRITE so the first contested grant favours the read side.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_last_grant <= OWN_WRITE;
        end else if (i_update && o_valid) begin
            r_last_grant <= o_owner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_req_arbiter
// Brief    : Shares the AHB master command port between the pixel fetch
//            (read) and writeback (write) units, one transaction at a time.
// Revision : 1.0
// ============================================================================
module ahb_req_arbiter
    import ahb_pkg::*;
#(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 7
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic       rd_done,
    output logic [7:0] rd_data,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_done,
    output logic       err,
    output logic [1:0] instruction,
    output logic [7:0] addr_r,
    output logic [7:0] addr_w,
    output logic [7:0] data_w,
    input  logic [7:0] data_r,
    input  logic       busy
);

    localparam logic [CNT_W-1:0] c_min_wait = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);

    state_t           r_state, w_state;
    owner_t           r_owner, w_owner;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt;

    logic       w_grant_valid;
    owner_t     w_grant_owner;
    logic       w_rd_ack, w_rd_done, w_wr_ack, w_wr_done, w_err;
    logic [7:0] w_rd_data, w_addr_r, w_addr_w, w_data_w;
    logic [1:0] w_instruction;

    rr_arb2 u_rr_arb2 (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .i_req_rd (rd_req),
        .i_req_wr (wr_req),
        .i_update (r_state == IDLE),
        .o_valid  (w_grant_valid),
        .o_owner  (w_grant_owner)
    );

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_owner       = r_owner;
        w_wait_cnt    = r_wait_cnt;
        w_rd_ack      = 1'b0;
        w_rd_done     = 1'b0;
        w_wr_ack      = 1'b0;
        w_wr_done     = 1'b0;
        w_err         = 1'b0;
        w_rd_data     = rd_data;
        w_instruction = instruction;
        w_addr_r      = addr_r;
        w_addr_w      = addr_w;
        w_data_w      = data_w;

        case (r_state)
            IDLE: begin
                w_instruction = INSTR_IDLE;
                if (w_grant_valid) begin
                    w_state    = ISSUE;
                    w_owner    = w_grant_owner;
                    w_wait_cnt = '0;
                    if (w_grant_owner == OWN_READ) begin
                        w_rd_ack      = 1'b1;
                        w_instruction = INSTR_READ;
                        w_addr_r      = rd_addr;
                    end else begin
                        w_wr_ack      = 1'b1;
                        w_instruction = INSTR_WRITE;
                        w_addr_w      = wr_addr;
                        w_data_w      = wr_data;
                    end
                end
            end
            ISSUE: begin
                // The counter reads 1 in the first WAIT cycle: it counts WAIT cycles.
                w_state    = WAIT;
                w_wait_cnt = r_wait_cnt + 1'b1;
            end
            WAIT: begin
                if ((r_wait_cnt >= c_min_wait) && !busy) begin
                    w_state       = IDLE;
                    w_instruction = INSTR_IDLE;
                    if (r_owner == OWN_READ) begin
                        w_rd_done = 1'b1;
                        w_rd_data = data_r;
                    end else begin
                        w_wr_done = 1'b1;
                    end
                end else if (r_wait_cnt == c_timeout) begin
                    w_state       = IDLE;
                    w_instruction = INSTR_IDLE;
                    w_err         = 1'b1;
                    if (r_owner == OWN_READ) begin
                        w_rd_done = 1'b1;
                    end else begin
                        w_wr_done = 1'b1;
                    end
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state       = IDLE;
                w_instruction = INSTR_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_owner     <= OWN_WRITE;
            r_wait_cnt  <= '0;
            rd_ack      <= 1'b0;
            rd_done     <= 1'b0;
            rd_data     <= 8'h00;
            wr_ack      <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
            instruction <= INSTR_IDLE;
            addr_r      <= 8'h00;
            addr_w      <= 8'h00;
            data_w      <= 8'h00;
        end else begin
            r_owner     <= w_owner;
            r_wait_cnt  <= w_wait_cnt;
            rd_ack      <= w_rd_ack;
            rd_done     <= w_rd_done;
            rd_data     <= w_rd_data;
            wr_ack      <= w_wr_ack;
            wr_done     <= w_wr_done;
            err         <= w_err;
            instruction <= w_instruction;
            addr_r      <= w_addr_r;
            addr_w      <= w_addr_w;
            data_w      <= w_data_w;
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_req_arbiter.md
Name: ahb_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-byte AHB master command port between two requesters: the pixel fetch unit (reads) and the result writeback unit (writes) of the Sobel pipeline. It accepts one transaction at a time and drives the master's instruction, address and data inputs. It uses the master's busy flag to detect completion, then returns read data and done/error pulses to the owning requester.

Parameters:
MIN_WAIT, 2, minimum WAIT cycles before completion may be declared (range 1..TIMEOUT-1)
TIMEOUT, 64, WAIT cycles after which the transaction is abandoned with an error
CNT_W, 7, width of the wait counter (must hold TIMEOUT)

Ports:
HCLK  in  1  system clock, all state on rising edge
HRESET  in  1  asynchronous active-low reset
rd_req  in  1  fetch unit read request; held with rd_addr until rd_ack
rd_addr  in  8  read byte address
rd_ack  out  1  one-cycle pulse: read request accepted
rd_done  out  1  one-cycle pulse: read finished, rd_data valid
rd_data  out  8  last completed read byte, held until next read completion
wr_req  in  1  writeback write request; held with wr_addr/wr_data until wr_ack
wr_addr  in  8  write byte address
wr_data  in  8  write byte
wr_ack  out  1  one-cycle pulse: write request accepted
wr_done  out  1  one-cycle pulse: write finished
err  out  1  one-cycle pulse with rd_done/wr_done on timeout
instruction  out  2  to master: 2'b00 idle, 2'b01 read, 2'b10 write
addr_r  out  8  to master read address
addr_w  out  8  to master write address
data_w  out  8  to master write data
data_r  in  8  from master read data
busy  in  1  from master, high while a transfer is outstanding

Behaviour:
- Clock HCLK, reset HRESET asynchronous active-low (decided). All outputs registered.
- Reset values: every output 0, state IDLE, wait_cnt 0, last_grant = WRITE (so the first contested grant goes to read). Reset asserted mid-transaction aborts it: no done/err pulse, instruction returns to 00 immediately.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if exactly one req is high, grant it. If both are high, grant the side other than last_grant. Next state ISSUE; latch the address (and write data) into the owner registers; update last_grant. If no req, stay in IDLE with instruction 00.
- ISSUE (exactly 1 cycle):
  - the owner's ack is high this cycle only;
  - instruction = 01 (read) or 10 (write);
  - addr_r / addr_w / data_w driven from the latched values; the unused address/data outputs hold their previous values;
  - wait_cnt cleared; next state WAIT.
- WAIT:
  - instruction held at its ISSUE value; addresses and data held stable;
  - wait_cnt increments each cycle, saturating at TIMEOUT.
  - Completion: when wait_cnt >= MIN_WAIT and busy == 0, the owner's done pulses next cycle and the FSM returns to IDLE with instruction 00. For a read, rd_data captures data_r on the completing edge.
  - Timeout: if wait_cnt == TIMEOUT and busy is still 1, done and err pulse together and rd_data is left unchanged. Return to IDLE.
- Turnaround: done pulses in the first IDLE cycle. A new grant can be made in that same cycle, so ISSUE follows the done cycle. Minimum transaction period is MIN_WAIT+2 cycles.
- Requester protocol: changing req, addr or data before ack is illegal. After ack, the requester may drop req or present the next request immediately; it is not re-granted before done.
- Simultaneous events:
  - a req arriving during ISSUE or WAIT waits in IDLE;
  - both reqs high in consecutive IDLE windows alternate strictly (R,W,R,W).
- Width rules: addresses and data are 8-bit pass-through, with no arithmetic. wait_cnt is CNT_W bits and must not wrap.

Decomposition:
- Shared package ahb_pkg:
  - instruction encodings INSTR_IDLE=2'b00, INSTR_READ=2'b01, INSTR_WRITE=2'b10;
  - typedef enum state_t {IDLE, ISSUE, WAIT};
  - typedef enum owner_t {OWN_READ, OWN_WRITE}.
- One natural sub-module: rr_arb2, the two-input round-robin grant with a last_grant register.
- The FSM and wait counter stay in the top block.

Test Plan:
- Single read: rd_req=1, rd_addr=8'h3C; master busy high for 4 cycles after ISSUE, data_r=8'hA5. Expect rd_ack 1 cycle after req, instruction=01 and addr_r=3C through WAIT, rd_done once, rd_data=A5, instruction back to 00.
- Single write: wr_req=1, wr_addr=8'h10, wr_data=8'h7F, busy low throughout. Expect instruction=10, addr_w=10, data_w=7F for 1+MIN_WAIT cycles, then wr_done once; total period 4 cycles.
- Contention: rd_req and wr_req both high from reset, each held for 3 transactions. Expect grant order R,W,R,W,R,W, exactly one ack and one done per grant, never two owners active.
- Timeout: read to 8'h55 with busy stuck at 1. Expect rd_done and err pulse together at WAIT cycle 64, rd_data unchanged from its previous value (8'hA5), then instruction returns to 00.
- Reset mid-WAIT: assert HRESET low 2 cycles after a write ISSUE. Expect all outputs 0 asynchronously and no wr_done. After release, a pending wr_req is re-granted and completes normally.
- Back-to-back same requester: wr_req held high for 5 writes with no rd_req. Expect 5 acks and 5 done pulses, ISSUE in the cycle after each done, and no idle gap beyond the single IDLE/done cycle.
